// File: rtl/intr_sched.sv
// Interrupt scheduler: fixed-priority arbitration of takeable interrupts, request/ack
// handshake to the trap unit, WFI wake-up. Optional WFI timeout via INTR_SCHED_WFI_TIMEOUT_EN.
module intr_sched #(
    parameter int XLEN           = 64,
    parameter int S_SUPPORTED    = 1,
    parameter int HOLDOFF_CYCLES = 2,
    parameter int TO_W           = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [11:0]     MIP_REGW,
    input  logic [11:0]     MIE_REGW,
    input  logic [11:0]     MIDELEG_REGW,
    input  logic [1:0]      PrivilegeModeW,
    input  logic            STATUS_MIE,
    input  logic            STATUS_SIE,
    input  logic            TrapBlockM,
    input  logic            IntAckM,
    input  logic            WFIM,
    input  logic [TO_W-1:0] WfiLimit,
    output logic            IntReqM,
    output logic [XLEN-1:0] IntCauseM,
    output logic            IntToSM,
    output logic            WFIWakeM,
    output logic            WFITimeoutM
);

    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [3:0] PRIO [6] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};
    localparam logic [11:0] STD_MASK = 12'hAAA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_next;
    logic [3:0]      r_code;
    logic [3:0]      w_code_next;
    logic            r_code_tos;
    logic            w_code_tos_next;
    logic            r_req;
    logic [XLEN-1:0] r_cause;
    logic            r_tos;
    logic            r_wake;

    logic [11:0]     w_pend;
    logic [11:0]     w_deleg;
    logic [15:0]     w_take;
    logic            w_deleg_ok;
    logic            w_mlevel_ok;
    logic            w_wake_now;
    logic [3:0]      w_sel_code;
    logic            w_sel_deleg;

    assign w_pend      = MIP_REGW & MIE_REGW;
    assign w_deleg     = (S_SUPPORTED != 0) ? MIDELEG_REGW : 12'h000;
    assign w_deleg_ok  = (PrivilegeModeW == 2'd0) | ((PrivilegeModeW == 2'd1) & STATUS_SIE);
    assign w_mlevel_ok = (PrivilegeModeW != 2'd3) | STATUS_MIE;
    assign w_wake_now  = WFIM & |(w_pend & STD_MASK);

    // Only the six standard interrupt bits (odd positions up to 11) can ever be taken.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_take
            if ((gi % 2 == 1) && (gi <= 11)) begin : g_std
                assign w_take[gi] = w_pend[gi] & (w_deleg[gi] ? w_deleg_ok : w_mlevel_ok);
            end else begin : g_rsv
                assign w_take[gi] = 1'b0;
            end
        end
    endgenerate

    // Scan lowest priority first so the highest-priority takeable bit wins.
    always_comb begin
        w_sel_code  = 4'd0;
        w_sel_deleg = 1'b0;
        for (int k = 5; k >= 0; k--) begin
            if (w_take[PRIO[k]]) begin
                w_sel_code  = PRIO[k];
                w_sel_deleg = w_deleg[PRIO[k]];
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_hold_next     = r_hold;
        w_code_next     = r_code;
        w_code_tos_next = r_code_tos;
        case (r_state)
            S_IDLE: begin
                if ((|w_take) && !TrapBlockM) begin
                    w_state_next    = S_REQ;
                    w_code_next     = w_sel_code;
                    w_code_tos_next = w_sel_deleg;
                end
            end
            S_REQ: begin
                if (IntAckM) begin
                    w_state_next = S_HOLD;
                    w_hold_next  = '0;
                end else if (!w_take[r_code]) begin
                    w_state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (r_hold == HW'(HOLDOFF_CYCLES - 1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_hold_next = r_hold + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_code     <= 4'd0;
            r_code_tos <= 1'b0;
            r_req      <= 1'b0;
            r_cause    <= '0;
            r_tos      <= 1'b0;
            r_wake     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold     <= w_hold_next;
            r_code     <= w_code_next;
            r_code_tos <= w_code_tos_next;
            r_req      <= (w_state_next == S_REQ);
            r_cause    <= (w_state_next == S_REQ) ? {1'b1, {(XLEN-5){1'b0}}, w_code_next} : '0;
            r_tos      <= (w_state_next == S_REQ) & w_code_tos_next;
            r_wake     <= w_wake_now;
        end
    end

    assign IntReqM   = r_req;
    assign IntCauseM = r_cause;
    assign IntToSM   = r_tos;
    assign WFIWakeM  = r_wake;

`ifdef INTR_SCHED_WFI_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_inc;
    logic            r_to;

    assign w_to_cnt_inc = r_to_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_to_cnt <= '0;
            r_to     <= 1'b0;
        end else if (!WFIM || w_wake_now) begin
            r_to_cnt <= '0;
            r_to     <= 1'b0;
        end else if ((WfiLimit != '0) && (w_to_cnt_inc == WfiLimit)) begin
            r_to_cnt <= '0;
            r_to     <= 1'b1;
        end else begin
            r_to_cnt <= w_to_cnt_inc;
            r_to     <= 1'b0;
        end
    end

    assign WFITimeoutM = r_to;

    logic w_unused_bits;
    assign w_unused_bits = ^{w_pend, w_deleg};
`else
    assign WFITimeoutM = 1'b0;

    logic w_unused_bits;
    assign w_unused_bits = ^{w_pend, w_deleg, WfiLimit};
`endif

endmodule

// File: tb/tb_intr_sched.sv
// Self-checking bench for intr_sched: directed scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_intr_sched;

    localparam int XLEN    = 64;
    localparam int S_SUP   = 1;
    localparam int HOLDOFF = 2;
    localparam int TO_W    = 16;
`ifdef INTR_SCHED_WFI_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [11:0]     MIP_REGW, MIE_REGW, MIDELEG_REGW;
    logic [1:0]      PrivilegeModeW;
    logic            STATUS_MIE, STATUS_SIE, TrapBlockM, IntAckM, WFIM;
    logic [TO_W-1:0] WfiLimit;
    logic            IntReqM, IntToSM, WFIWakeM, WFITimeoutM;
    logic [XLEN-1:0] IntCauseM;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit              m_busy;
    int              m_code;
    bit              m_tos;
    int              m_hold;
    bit              m_wake;
    bit              m_to;
    logic [TO_W-1:0] m_cnt;

    int prio [6] = '{11, 3, 7, 9, 1, 5};

    intr_sched #(
        .XLEN(XLEN), .S_SUPPORTED(S_SUP), .HOLDOFF_CYCLES(HOLDOFF), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset),
        .MIP_REGW(MIP_REGW), .MIE_REGW(MIE_REGW), .MIDELEG_REGW(MIDELEG_REGW),
        .PrivilegeModeW(PrivilegeModeW), .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE),
        .TrapBlockM(TrapBlockM), .IntAckM(IntAckM), .WFIM(WFIM), .WfiLimit(WfiLimit),
        .IntReqM(IntReqM), .IntCauseM(IntCauseM), .IntToSM(IntToSM),
        .WFIWakeM(WFIWakeM), .WFITimeoutM(WFITimeoutM)
    );

    always #5 clk = ~clk;

    function automatic bit takeable(int c);
        bit deleg;
        if (!(MIP_REGW[c] && MIE_REGW[c])) return 1'b0;
        deleg = (S_SUP != 0) && MIDELEG_REGW[c];
        if (deleg) return (PrivilegeModeW == 0) || (PrivilegeModeW == 1 && STATUS_SIE);
        return (PrivilegeModeW != 3) || STATUS_MIE;
    endfunction

    function automatic int pick();
        foreach (prio[k]) if (takeable(prio[k])) return prio[k];
        return -1;
    endfunction

    function automatic logic [63:0] cause_of(int c);
        return 64'h8000_0000_0000_0000 | 64'(c);
    endfunction

    task automatic model_edge();
        int  best;
        bit  wake_now;
        if (!reset) begin
            m_busy = 0; m_code = 0; m_tos = 0; m_hold = 0;
            m_wake = 0; m_to = 0; m_cnt = '0;
            return;
        end
        if (m_busy) begin
            if (IntAckM) begin
                m_busy = 0; m_hold = HOLDOFF;
            end else if (!takeable(m_code)) begin
                m_busy = 0;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            best = pick();
            if (best >= 0 && !TrapBlockM) begin
                m_busy = 1; m_code = best; m_tos = (S_SUP != 0) && MIDELEG_REGW[best];
            end
        end
        wake_now = WFIM && ((MIP_REGW & MIE_REGW & 12'hAAA) != 0);
        m_wake = wake_now;
        m_to = 0;
        if (TO_EN) begin
            if (!WFIM || wake_now) begin
                m_cnt = '0;
            end else begin
                m_cnt = m_cnt + 1'b1;
                if (WfiLimit != 0 && m_cnt == WfiLimit) begin
                    m_to = 1; m_cnt = '0;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("req",     64'(IntReqM),     64'(m_busy));
        chk("cause",   IntCauseM,        m_busy ? cause_of(m_code) : 64'h0);
        chk("tos",     64'(IntToSM),     64'(m_busy && m_tos));
        chk("wake",    64'(WFIWakeM),    64'(m_wake));
        chk("timeout", 64'(WFITimeoutM), 64'(m_to));
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ack_and_settle();
        MIP_REGW = 12'h000; IntAckM = 1'b1; step();
        IntAckM = 1'b0; steps(3);
    endtask

    initial begin
        reset = 1'b0; MIP_REGW = '0; MIE_REGW = '0; MIDELEG_REGW = '0;
        PrivilegeModeW = 2'd0; STATUS_MIE = 0; STATUS_SIE = 0; TrapBlockM = 0;
        IntAckM = 0; WFIM = 0; WfiLimit = '0;
        steps(2);
        chk("reset_req", 64'(IntReqM), 64'd0);
        chk("reset_cause", IntCauseM, 64'd0);

        // priority: MEI first, then MSI after the holdoff
        reset = 1'b1; MIP_REGW = 12'hAAA; MIE_REGW = 12'hAAA;
        step();
        chk("prio_mei", IntCauseM, 64'h8000_0000_0000_000B);
        chk("prio_tos", 64'(IntToSM), 64'd0);
        MIP_REGW = 12'h2AA; IntAckM = 1'b1; step();
        IntAckM = 1'b0; steps(2);
        chk("prio_gap", 64'(IntReqM), 64'd0);
        step();
        chk("prio_msi", IntCauseM, 64'h8000_0000_0000_0003);
        ack_and_settle();

        // delegation: never taken in M, taken in S with SIE
        PrivilegeModeW = 2'd3; STATUS_MIE = 1; MIP_REGW = 12'h020; MIE_REGW = 12'h020;
        MIDELEG_REGW = 12'h020;
        steps(2);
        chk("deleg_m_blocked", 64'(IntReqM), 64'd0);
        PrivilegeModeW = 2'd1; STATUS_SIE = 1; step();
        chk("deleg_sti", IntCauseM, 64'h8000_0000_0000_0005);
        chk("deleg_tos", 64'(IntToSM), 64'd1);

        // stability: MEI arrives while STI is presented
        MIP_REGW = 12'h820; MIE_REGW = 12'h820; steps(2);
        chk("stable_cause", IntCauseM, 64'h8000_0000_0000_0005);
        IntAckM = 1'b1; step();
        IntAckM = 1'b0; steps(2);
        chk("holdoff_low", 64'(IntReqM), 64'd0);
        step();
        chk("holdoff_mei", IntCauseM, 64'h8000_0000_0000_000B);
        ack_and_settle();

        // withdraw, then withdraw coinciding with ack
        PrivilegeModeW = 2'd3; STATUS_MIE = 1; MIDELEG_REGW = '0;
        MIP_REGW = 12'h080; MIE_REGW = 12'h080; step();
        chk("wd_mti", IntCauseM, 64'h8000_0000_0000_0007);
        MIP_REGW = 12'h000; step();
        chk("wd_drop", 64'(IntReqM), 64'd0);
        MIP_REGW = 12'h080; step();
        chk("wd_rereq", 64'(IntReqM), 64'd1);
        MIP_REGW = 12'h000; IntAckM = 1'b1; step();
        IntAckM = 1'b0; MIP_REGW = 12'h080; step();
        chk("wd_ack_hold", 64'(IntReqM), 64'd0);
        steps(2);
        chk("wd_after_hold", 64'(IntReqM), 64'd1);
        ack_and_settle();

        // trap block and reset during request
        TrapBlockM = 1'b1; MIP_REGW = 12'h080; steps(2);
        chk("tb_blocked", 64'(IntReqM), 64'd0);
        TrapBlockM = 1'b0; step();
        chk("tb_release", IntCauseM, 64'h8000_0000_0000_0007);
        reset = 1'b0; step();
        chk("rst_req", 64'(IntReqM), 64'd0);
        chk("rst_cause", IntCauseM, 64'd0);
        reset = 1'b1; MIP_REGW = 12'h000; steps(2);

        // WFI timeout and wake
        MIE_REGW = 12'h000; WfiLimit = 16'd4; WFIM = 1'b1; steps(4);
        chk("wfi_to_pulse", 64'(WFITimeoutM), 64'(TO_EN));
        step();
        chk("wfi_to_once", 64'(WFITimeoutM), 64'd0);
        MIP_REGW = 12'h008; MIE_REGW = 12'h008; STATUS_MIE = 0; PrivilegeModeW = 2'd3;
        step();
        chk("wfi_wake", 64'(WFIWakeM), 64'd1);
        chk("wfi_no_req", 64'(IntReqM), 64'd0);
        step();
        MIP_REGW = 12'h000; steps(6);
        WFIM = 1'b0; steps(2);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) MIP_REGW = 12'($urandom);
            if ($urandom_range(7) == 0) MIE_REGW = 12'($urandom);
            if ($urandom_range(7) == 0) MIDELEG_REGW = 12'($urandom);
            if ($urandom_range(7) == 0) PrivilegeModeW = 2'($urandom);
            if ($urandom_range(5) == 0) STATUS_MIE = 1'($urandom);
            if ($urandom_range(5) == 0) STATUS_SIE = 1'($urandom);
            if ($urandom_range(15) == 0) WfiLimit = 16'($urandom_range(6));
            if ($urandom_range(9) == 0) WFIM = 1'($urandom);
            TrapBlockM = ($urandom_range(9) == 0);
            IntAckM    = ($urandom_range(3) == 0);
            reset      = ($urandom_range(63) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_sched.md
# intr_sched

Interrupt scheduler between the interrupt CSR file and the trap/privilege pipeline logic. Each cycle it combines pending (MIP), enable (MIE) and delegation (MIDELEG) state with the current privilege mode and global enables. It selects the highest-priority takeable interrupt and presents it to the trap unit through a request/acknowledge handshake, holding the cause stable until the request is taken or withdrawn. It also generates WFI wake-up and, optionally, a WFI timeout.

## Interface
- XLEN, 64, width of the cause output.
- S_SUPPORTED, 1, when 0 delegation is ignored and all interrupts are M-level.
- HOLDOFF_CYCLES, 2, cycles after an acknowledge before a new arbitration (≥1).
- TO_W, 16, width of the WFI timeout counter and limit.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- MIP_REGW  in  12  pending bits.
- MIE_REGW  in  12  enable bits.
- MIDELEG_REGW  in  12  delegation bits.
- PrivilegeModeW  in  2  current mode (3=M, 1=S, 0=U).
- STATUS_MIE, STATUS_SIE  in  1 each  global interrupt enables.
- TrapBlockM  in  1  exception or trap already in flight; blocks new arbitration.
- IntAckM  in  1  trap unit has taken the presented interrupt.
- WFIM  in  1  WFI instruction stalled in M stage.
- WfiLimit  in  TO_W  WFI timeout limit (macro only).
- IntReqM  out  1  interrupt request to the trap unit.
- IntCauseM  out  XLEN  {1'b1, zero-extended 4-bit code}.
- IntToSM  out  1  presented interrupt traps to S mode.
- WFIWakeM  out  1  WFI may retire.
- WFITimeoutM  out  1  one-cycle timeout pulse.

## Operation
- Candidates: Pend = MIP_REGW & MIE_REGW.
- Fixed priority, highest first: MEI(11), MSI(3), MTI(7), SEI(9), SSI(1), STI(5). All other bits are ignored.
- Bit i is delegated when S_SUPPORTED & MIDELEG_REGW[i].
- A non-delegated bit is takeable when mode<M, or when mode==M & STATUS_MIE.
- A delegated bit is takeable when mode==U, or when mode==S & STATUS_SIE. It is never takeable in M.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: if any bit is takeable and !TrapBlockM, latch the highest-priority takeable code and its delegation, then go to REQ.
  - REQ: IntReqM=1; IntCauseM and IntToSM are frozen, with no re-arbitration even if a higher-priority bit arrives.
    - IntAckM → HOLD.
    - Else, if the latched bit is no longer takeable → IDLE (withdraw).
    - IntAckM and loss of takeability in the same cycle: the acknowledge wins.
  - HOLD: count HOLDOFF_CYCLES cycles, then go to IDLE. This lets mstatus/mode updates settle.
- IntAckM outside REQ is ignored.
- Cause and delegation outputs are 0 when not in REQ.
- WFIWakeM = WFIM & |(Pend[11:0] restricted to the six standard bits). Global enables and privilege do not affect it.

## Timing
- Reset (reset==0 at a clk edge): state IDLE; IntReqM=0, IntCauseM=0, IntToSM=0, WFIWakeM=0, WFITimeoutM=0; timeout counter 0.
- Reset asserted while in any state returns to IDLE on the next edge; a pending request is dropped without an acknowledge.
- All outputs are registered.
- IntReqM rises 1 cycle after a takeable bit is seen in IDLE.
- IntReqM falls 1 cycle after the acknowledge or the withdraw condition.
- Minimum gap between two requests is HOLDOFF_CYCLES+1 cycles of IntReqM=0.
- WFIWakeM lags its inputs by 1 cycle.

## Configuration
- INTR_SCHED_WFI_TIMEOUT_EN defined:
  - A TO_W-bit counter increments each cycle that WFIM=1 and WFIWakeM=0; it clears when WFIM=0 or on wake.
  - When the counter equals WfiLimit (nonzero), WFITimeoutM pulses high for 1 cycle and the counter clears.
  - WfiLimit=0 disables the timeout.
- INTR_SCHED_WFI_TIMEOUT_EN undefined: no counter, WfiLimit is unused, WFITimeoutM is tied to 0.

## Test plan
- Priority: mode=U; MIP=MIE=0xAAA; MIDELEG=0 → IntReqM=1 after 1 cycle, IntCauseM={1,..,11}, IntToSM=0. Clear MEI and acknowledge, then wait out HOLD → next cause 3.
- Delegation: mode=M, STATUS_MIE=1, MIP=MIE=0x020, MIDELEG=0x020 → IntReqM stays 0. Switch to mode=S, STATUS_SIE=1 → cause 5, IntToSM=1.
- Withdraw: in REQ with cause 7, drop MIP[7] with IntAckM=0 → IntReqM=0 next cycle, state IDLE. Repeat with IntAckM=1 in the same cycle → HOLD is entered.
- Stability and holdoff: in REQ with cause 5, raise MEI → cause stays 5 until IntAckM. After the acknowledge, IntReqM stays 0 for exactly HOLDOFF_CYCLES+1 cycles, then a request with cause 11 is presented.
- TrapBlock and reset: TrapBlockM=1 with MTI takeable → no request; release → request next cycle. Drive reset=0 during REQ → all outputs 0 next edge.
- WFI (macro defined): WfiLimit=4, WFIM=1, no pending interrupts → WFITimeoutM pulses once after the 4th counted cycle. Raising MIP=MIE=0x008 with STATUS_MIE=0 in mode M → WFIWakeM=1 next cycle and the counter clears.
